// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer command path: arbiter state encoding,
// command byte width/constants and the legal requester range.
package buzzer_pkg;

    localparam int BZ_DATA_W      = 8;
    localparam int BZ_NUM_REQ_MIN = 2;
    localparam int BZ_NUM_REQ_MAX = 4;

    localparam logic [7:0] BZ_CMD_ESC = 8'h1B;
    localparam logic [7:0] BZ_CMD_D   = 8'h44;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CHECK = 4'd1,
        ST_WRITE = 4'd2,
        ST_DONE  = 4'd3
    } bz_state_t;

endpackage

// File: rtl/buzzer_cmd_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above the pointer,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter
    import buzzer_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(ptr) + k) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (!found && req[cand_idx]) begin
                found              = 1'b1;
                grant_oh[cand_idx] = 1'b1;
                grant_idx          = cand_idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/buzzer_cmd_arbiter.sv
// Shares the single BUZZER_INTERFACE write port among NUM_REQ command sources;
// bursts are atomic and each written byte is followed by a mandatory idle cycle.
module buzzer_cmd_arbiter
    import buzzer_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = BZ_DATA_W
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic [NUM_REQ-1:0]        Req_Sig,
    input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
    input  logic [NUM_REQ-1:0]        Req_Last,
    output logic [NUM_REQ-1:0]        Data_Take,
    output logic [NUM_REQ-1:0]        Done_Sig,
    output logic                      Busy_Sig,
    input  logic                      Full_Sig,
    output logic                      Write_Req_Sig,
    output logic [DATA_W-1:0]         FIFO_Write_Data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    bz_state_t          state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx_r;
    logic [NUM_REQ-1:0] grant_oh_r;
    logic               last_r;

    logic [NUM_REQ-1:0] arb_oh;
    logic [IDX_W-1:0]   arb_idx;
    logic               any_req;

    logic               sel_req;
    logic               sel_last;
    logic [DATA_W-1:0]  sel_data;
    logic [IDX_W-1:0]   ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (Req_Sig),
        .ptr       (rr_ptr),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .any_req   (any_req)
    );

    always_comb begin
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh_r[i]) begin
                sel_req  = Req_Sig[i];
                sel_last = Req_Last[i];
                sel_data = Req_Data[i*DATA_W +: DATA_W];
            end
        end
    end

    // After a finished or aborted burst the granted source becomes lowest priority.
    assign ptr_next = (grant_idx_r == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_r + 1'b1;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state           <= ST_IDLE;
            rr_ptr          <= '0;
            grant_idx_r     <= '0;
            grant_oh_r      <= '0;
            last_r          <= 1'b0;
            Data_Take       <= '0;
            Done_Sig        <= '0;
            Busy_Sig        <= 1'b0;
            Write_Req_Sig   <= 1'b0;
            FIFO_Write_Data <= '0;
        end else begin
            Write_Req_Sig <= 1'b0;
            Data_Take     <= '0;
            Done_Sig      <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_idx_r <= arb_idx;
                        grant_oh_r  <= arb_oh;
                        Busy_Sig    <= 1'b1;
                        state       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!sel_req) begin
                        rr_ptr   <= ptr_next;
                        Busy_Sig <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (!Full_Sig) begin
                        Write_Req_Sig   <= 1'b1;
                        FIFO_Write_Data <= sel_data;
                        Data_Take       <= grant_oh_r;
                        last_r          <= sel_last;
                        state           <= ST_WRITE;
                    end
                end
                // Idle cycle after every pulse so Full_Sig reflects the new byte.
                ST_WRITE: begin
                    if (last_r) begin
                        Done_Sig <= grant_oh_r;
                        state    <= ST_DONE;
                    end else begin
                        state <= ST_CHECK;
                    end
                end
                ST_DONE: begin
                    rr_ptr   <= ptr_next;
                    Busy_Sig <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    Busy_Sig <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buzzer_cmd_arbiter.sv
// Directed bench for buzzer_cmd_arbiter with two reactive command sources.
module tb_buzzer_cmd_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 8;

    logic                      CLK = 1'b0;
    logic                      RSTn = 1'b1;
    logic [NUM_REQ-1:0]        Req_Sig = '0;
    logic [NUM_REQ*DATA_W-1:0] Req_Data = '0;
    logic [NUM_REQ-1:0]        Req_Last = '0;
    logic [NUM_REQ-1:0]        Data_Take;
    logic [NUM_REQ-1:0]        Done_Sig;
    logic                      Busy_Sig;
    logic                      Full_Sig = 1'b0;
    logic                      Write_Req_Sig;
    logic [DATA_W-1:0]         FIFO_Write_Data;

    buzzer_cmd_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .Req_Sig         (Req_Sig),
        .Req_Data        (Req_Data),
        .Req_Last        (Req_Last),
        .Data_Take       (Data_Take),
        .Done_Sig        (Done_Sig),
        .Busy_Sig        (Busy_Sig),
        .Full_Sig        (Full_Sig),
        .Write_Req_Sig   (Write_Req_Sig),
        .FIFO_Write_Data (FIFO_Write_Data)
    );

    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [7:0] src_bytes [2][4];
    int         src_len [2];
    int         src_idx [2];
    int         src_bursts [2];
    int         src_takes [2];
    int         src_drop_after [2];

    logic [7:0] wr_log [$];
    int         done_log [$];
    int         done_cyc [$];

    task automatic present();
        for (int i = 0; i < 2; i++) begin
            Req_Sig[i]          = (src_bursts[i] > 0);
            Req_Data[i*8 +: 8]  = src_bytes[i][src_idx[i]];
            Req_Last[i]         = (src_idx[i] == src_len[i] - 1);
        end
    endtask

    task automatic setup_src(input int i, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int len, input int bursts,
                             input int drop_after);
        src_bytes[i][0]   = b0;
        src_bytes[i][1]   = b1;
        src_bytes[i][2]   = b2;
        src_bytes[i][3]   = 8'h00;
        src_len[i]        = len;
        src_idx[i]        = 0;
        src_bursts[i]     = bursts;
        src_takes[i]      = 0;
        src_drop_after[i] = drop_after;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        done_log.delete();
        done_cyc.delete();
        cyc = 0;
    endtask

    // Advance one clock, sample outputs 1 time unit after the edge, then let the sources react.
    task automatic clk_step();
        @(posedge CLK);
        #1;
        cyc++;
        if (Write_Req_Sig) wr_log.push_back(FIFO_Write_Data);
        for (int i = 0; i < 2; i++) begin
            if (Data_Take[i]) begin
                src_takes[i]++;
                if (src_idx[i] < src_len[i] - 1) src_idx[i]++;
                if (src_takes[i] == src_drop_after[i]) src_bursts[i] = 0;
            end
            if (Done_Sig[i]) begin
                done_log.push_back(i);
                done_cyc.push_back(cyc);
                src_idx[i] = 0;
                if (src_bursts[i] > 0) src_bursts[i]--;
            end
        end
        present();
    endtask

    task automatic do_reset();
        RSTn     = 1'b0;
        Full_Sig = 1'b0;
        setup_src(0, 8'h00, 8'h00, 8'h00, 1, 0, -1);
        setup_src(1, 8'h00, 8'h00, 8'h00, 1, 0, -1);
        present();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        clear_logs();
    endtask

    task automatic test_reset();
        RSTn = 1'b1;
        #2;
        RSTn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        compared++;
        if ({Write_Req_Sig, Data_Take, Done_Sig, Busy_Sig} !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctl: got %b expected %b", {Write_Req_Sig, Data_Take, Done_Sig, Busy_Sig}, 6'b0);
        end
        compared++;
        if (FIFO_Write_Data !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got %h expected %h", FIFO_Write_Data, 8'h00);
        end
        do_reset();
        repeat (3) clk_step();
        compared++;
        if ({Write_Req_Sig, Busy_Sig} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL idle_no_req: got %b expected %b", {Write_Req_Sig, Busy_Sig}, 2'b00);
        end
    endtask

    task automatic test_single_burst();
        logic [5:0] exp_ctl [1:8];
        logic [7:0] exp_data [1:8];
        exp_ctl = '{6'b0_00_00_1, 6'b1_01_00_1, 6'b0_00_00_1, 6'b1_01_00_1,
                    6'b0_00_00_1, 6'b1_01_00_1, 6'b0_00_01_1, 6'b0_00_00_0};
        exp_data = '{8'h00, 8'h1B, 8'h1B, 8'h44, 8'h44, 8'h1B, 8'h1B, 8'h1B};
        do_reset();
        setup_src(0, 8'h1B, 8'h44, 8'h1B, 3, 1, -1);
        present();
        for (int c = 1; c <= 8; c++) begin
            clk_step();
            compared++;
            if ({Write_Req_Sig, Data_Take, Done_Sig, Busy_Sig} !== exp_ctl[c]) begin
                mismatched++;
                $display("[TB] FAIL single_ctl c%0d: got %b expected %b", c,
                         {Write_Req_Sig, Data_Take, Done_Sig, Busy_Sig}, exp_ctl[c]);
            end
            compared++;
            if (FIFO_Write_Data !== exp_data[c]) begin
                mismatched++;
                $display("[TB] FAIL single_data c%0d: got %h expected %h", c, FIFO_Write_Data, exp_data[c]);
            end
        end
    endtask

    task automatic test_two_sources();
        logic [7:0] exp_wr [4];
        exp_wr = '{8'hA1, 8'hA2, 8'hB1, 8'hB2};
        do_reset();
        setup_src(0, 8'hA1, 8'hA2, 8'h00, 2, 1, -1);
        setup_src(1, 8'hB1, 8'hB2, 8'h00, 2, 1, -1);
        present();
        while (done_log.size() < 2 && cyc < 40) clk_step();
        compared++;
        if (done_log.size() != 2) begin
            mismatched++;
            $display("[TB] FAIL two_timeout: got %0d dones expected %0d", done_log.size(), 2);
        end else begin
            compared++;
            if (done_log[0] != 0 || done_log[1] != 1) begin
                mismatched++;
                $display("[TB] FAIL two_done_order: got %0d,%0d expected 0,1", done_log[0], done_log[1]);
            end
            compared++;
            if (done_cyc[0] != 5 || done_cyc[1] != 11) begin
                mismatched++;
                $display("[TB] FAIL two_done_cycle: got %0d,%0d expected 5,11", done_cyc[0], done_cyc[1]);
            end
        end
        compared++;
        if (wr_log.size() != 4) begin
            mismatched++;
            $display("[TB] FAIL two_wr_count: got %0d expected %0d", wr_log.size(), 4);
        end else begin
            for (int k = 0; k < 4; k++) begin
                compared++;
                if (wr_log[k] !== exp_wr[k]) begin
                    mismatched++;
                    $display("[TB] FAIL two_wr_byte%0d: got %h expected %h", k, wr_log[k], exp_wr[k]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int multi = 0;
        int exp_order [6];
        exp_order = '{0, 1, 0, 1, 0, 1};
        do_reset();
        setup_src(0, 8'h1B, 8'h44, 8'h00, 2, 3, -1);
        setup_src(1, 8'h51, 8'h52, 8'h00, 2, 3, -1);
        present();
        while (done_log.size() < 6 && cyc < 100) begin
            clk_step();
            if ($countones(Data_Take) > 1 || $countones(Done_Sig) > 1) multi++;
        end
        compared++;
        if (done_log.size() != 6) begin
            mismatched++;
            $display("[TB] FAIL rr_timeout: got %0d dones expected %0d", done_log.size(), 6);
        end else begin
            for (int k = 0; k < 6; k++) begin
                compared++;
                if (done_log[k] != exp_order[k]) begin
                    mismatched++;
                    $display("[TB] FAIL rr_grant%0d: got %0d expected %0d", k, done_log[k], exp_order[k]);
                end
            end
        end
        compared++;
        if (multi != 0) begin
            mismatched++;
            $display("[TB] FAIL rr_onehot: got %0d multi-source cycles expected 0", multi);
        end
        compared++;
        if (wr_log.size() != 12) begin
            mismatched++;
            $display("[TB] FAIL rr_wr_count: got %0d expected %0d", wr_log.size(), 12);
        end
    endtask

    task automatic test_full_stall();
        int stall_writes = 0;
        do_reset();
        Full_Sig = 1'b1;
        setup_src(0, 8'h1B, 8'h44, 8'h00, 2, 1, -1);
        present();
        for (int c = 1; c <= 10; c++) begin
            clk_step();
            if (c <= 6 && (Write_Req_Sig || Data_Take != 2'b00)) stall_writes++;
            if (c == 6) Full_Sig = 1'b0;
            if (c == 7) begin
                compared++;
                if ({Write_Req_Sig, Data_Take, FIFO_Write_Data} !== {1'b1, 2'b01, 8'h1B}) begin
                    mismatched++;
                    $display("[TB] FAIL full_release_write: got %b %b %h expected 1 01 1b",
                             Write_Req_Sig, Data_Take, FIFO_Write_Data);
                end
            end
            if (c == 9) begin
                compared++;
                if ({Write_Req_Sig, FIFO_Write_Data} !== {1'b1, 8'h44}) begin
                    mismatched++;
                    $display("[TB] FAIL full_second_write: got %b %h expected 1 44", Write_Req_Sig, FIFO_Write_Data);
                end
            end
            if (c == 10) begin
                compared++;
                if (Done_Sig !== 2'b01) begin
                    mismatched++;
                    $display("[TB] FAIL full_done: got %b expected %b", Done_Sig, 2'b01);
                end
            end
        end
        compared++;
        if (stall_writes != 0) begin
            mismatched++;
            $display("[TB] FAIL full_stall: got %0d writes while full expected 0", stall_writes);
        end
    endtask

    task automatic test_abort();
        int done1 = 0;
        do_reset();
        setup_src(0, 8'hA5, 8'h00, 8'h00, 1, 0, -1);
        setup_src(1, 8'hC1, 8'hC2, 8'hC3, 3, 1, 1);
        present();
        for (int c = 1; c <= 8; c++) begin
            clk_step();
            if (Done_Sig[1]) done1++;
            if (c == 2) begin
                compared++;
                if ({Write_Req_Sig, Data_Take, FIFO_Write_Data} !== {1'b1, 2'b10, 8'hC1}) begin
                    mismatched++;
                    $display("[TB] FAIL abort_first_write: got %b %b %h expected 1 10 c1",
                             Write_Req_Sig, Data_Take, FIFO_Write_Data);
                end
                src_bursts[0] = 1;
                present();
            end
            if (c == 4) begin
                compared++;
                if ({Busy_Sig, Write_Req_Sig} !== 2'b00) begin
                    mismatched++;
                    $display("[TB] FAIL abort_busy: got %b expected %b", {Busy_Sig, Write_Req_Sig}, 2'b00);
                end
            end
            if (c == 6) begin
                compared++;
                if ({Write_Req_Sig, Data_Take, FIFO_Write_Data} !== {1'b1, 2'b01, 8'hA5}) begin
                    mismatched++;
                    $display("[TB] FAIL abort_next_grant: got %b %b %h expected 1 01 a5",
                             Write_Req_Sig, Data_Take, FIFO_Write_Data);
                end
            end
            if (c == 7) begin
                compared++;
                if (Done_Sig !== 2'b01) begin
                    mismatched++;
                    $display("[TB] FAIL abort_done0: got %b expected %b", Done_Sig, 2'b01);
                end
            end
        end
        compared++;
        if (done1 != 0 || wr_log.size() != 2) begin
            mismatched++;
            $display("[TB] FAIL abort_no_done1: got done1=%0d writes=%0d expected done1=0 writes=2", done1, wr_log.size());
        end
    endtask

    task automatic test_reset_midburst();
        logic [7:0] exp_wr [4];
        exp_wr = '{8'hD0, 8'hC1, 8'hC2, 8'hC3};
        do_reset();
        setup_src(0, 8'hD0, 8'h00, 8'h00, 1, 1, -1);
        setup_src(1, 8'hC1, 8'hC2, 8'hC3, 3, 1, -1);
        present();
        while (src_takes[1] < 2 && cyc < 30) clk_step();
        compared++;
        if (src_takes[1] != 2) begin
            mismatched++;
            $display("[TB] FAIL mid_timeout: got %0d takes expected %0d", src_takes[1], 2);
        end
        #2;
        RSTn = 1'b0;
        #1;
        compared++;
        if ({Write_Req_Sig, Data_Take, Done_Sig, Busy_Sig, FIFO_Write_Data} !== 14'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_async_reset: got %b expected all zero",
                     {Write_Req_Sig, Data_Take, Done_Sig, Busy_Sig, FIFO_Write_Data});
        end
        setup_src(0, 8'hD0, 8'h00, 8'h00, 1, 1, -1);
        setup_src(1, 8'hC1, 8'hC2, 8'hC3, 3, 1, -1);
        present();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        clear_logs();
        clk_step();
        clk_step();
        compared++;
        if ({Write_Req_Sig, Data_Take, FIFO_Write_Data} !== {1'b1, 2'b01, 8'hD0}) begin
            mismatched++;
            $display("[TB] FAIL mid_ptr_zero: got %b %b %h expected 1 01 d0",
                     Write_Req_Sig, Data_Take, FIFO_Write_Data);
        end
        while (done_log.size() < 2 && cyc < 40) clk_step();
        compared++;
        if (wr_log.size() != 4) begin
            mismatched++;
            $display("[TB] FAIL mid_wr_count: got %0d expected %0d", wr_log.size(), 4);
        end else begin
            for (int k = 0; k < 4; k++) begin
                compared++;
                if (wr_log[k] !== exp_wr[k]) begin
                    mismatched++;
                    $display("[TB] FAIL mid_wr_byte%0d: got %h expected %h", k, wr_log[k], exp_wr[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_two_sources();
        test_round_robin();
        test_full_stall();
        test_abort();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
